// File: rtl/even_parity_pkg.sv
// Shared definitions for the even-parity serial link: FSM state encoding
// and the line levels used for idle, start and stop.
package even_parity_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t START  = 3'd1;
  localparam state_t DATA   = 3'd2;
  localparam state_t PARITY = 3'd3;
  localparam state_t STOP   = 3'd4;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/even_parity_gen.sv
// Combinational even-parity generator: p makes {d, p} XOR to zero.
// Shared with the receive-side checker loopback.
module even_parity_gen #(
  parameter int W = 4
) (
  input  logic [W-1:0] d,
  output logic         p
);

  assign p = ^d;

endmodule

// File: rtl/even_parity_serial_tx.sv
// Even-parity serial transmitter: accepts a word on valid/ready, presents
// the registered code word {data, parity} and sends the frame
// start(0), data LSB-first, parity, stop(1), each bit held BIT_CYCLES clocks.
module even_parity_serial_tx
  import even_parity_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter int BIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_serial,
  output logic [DATA_W:0]   code_word,
  output logic              busy,
  output logic              frame_done
);

  localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [DATA_W-1:0] shift, shift_n;
  logic              parity_q, parity_n;
  logic              tx_n;
  logic              in_parity;
  logic              accept;
  logic              tick;

  even_parity_gen #(.W(DATA_W)) u_gen (
    .d (in_data),
    .p (in_parity)
  );

  assign accept = in_valid && in_ready;
  // With BIT_CYCLES=1 the counter stays at 0 and every cycle is a bit end.
  assign tick   = (cnt == CNT_LAST);

  // Next-state logic for the FSM, bit-cycle counter, bit index and shifter.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_n  = state;
    idx_n    = idx;
    shift_n  = shift;
    parity_n = parity_q;
    cnt_n    = (state == IDLE || tick) ? '0 : cnt + 1'b1;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n  = START;
          shift_n  = in_data;
          parity_n = in_parity;
        end
      end
      START: begin
        if (tick) begin
          state_n = DATA;
          idx_n   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          shift_n = shift >> 1;
          if (idx == IDX_LAST) state_n = PARITY;
          else                 idx_n   = idx + 1'b1;
        end
      end
      PARITY: if (tick) state_n = STOP;
      STOP:   if (tick) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Line level for the cycle that follows, so tx_serial can be a plain flop.
  always_comb begin
    tx_n = LINE_IDLE;
    case (state_n)
      START:   tx_n = START_BIT;
      DATA:    tx_n = shift_n[0];
      PARITY:  tx_n = parity_n;
      STOP:    tx_n = STOP_BIT;
      default: tx_n = LINE_IDLE;
    endcase
  end

  // State and registered outputs; reset drives the line idle without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shift      <= '0;
      parity_q   <= 1'b0;
      tx_serial  <= LINE_IDLE;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      code_word  <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      shift      <= shift_n;
      parity_q   <= parity_n;
      tx_serial  <= tx_n;
      in_ready   <= (state_n == IDLE);
      busy       <= (state_n != IDLE);
      frame_done <= (state_n == STOP) && (cnt_n == CNT_LAST);
      if (accept) code_word <= {in_data, in_parity};
    end
  end

endmodule

// File: tb/tb_even_parity_serial_tx.sv
// Bench for even_parity_serial_tx: one instance with BIT_CYCLES=1 and one
// with BIT_CYCLES=3, selected by 'sel'. Expected line levels come from a
// frame model built from the data word; code words come from a hand table.
module tb_even_parity_serial_tx;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [D-1:0] in_data;
  logic in_valid;
  logic sel;   // 0: BIT_CYCLES=1 instance, 1: BIT_CYCLES=3 instance

  logic v1, r1, t1, b1, f1;
  logic v3, r3, t3, b3, f3;
  logic [D:0] c1, c3;
  logic rdy, tx, bsy, done;
  logic [D:0] code;

  always #5 clk = ~clk;

  assign v1   = in_valid & ~sel;
  assign v3   = in_valid & sel;
  assign rdy  = sel ? r3 : r1;
  assign tx   = sel ? t3 : t1;
  assign bsy  = sel ? b3 : b1;
  assign done = sel ? f3 : f1;
  assign code = sel ? c3 : c1;

  even_parity_serial_tx #(.DATA_W(D), .BIT_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(v1), .in_ready(r1),
    .tx_serial(t1), .code_word(c1), .busy(b1), .frame_done(f1)
  );

  even_parity_serial_tx #(.DATA_W(D), .BIT_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(v3), .in_ready(r3),
    .tx_serial(t3), .code_word(c3), .busy(b3), .frame_done(f3)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [D-1:0] data;
    logic [D:0]   code;
  } vec_t;

  vec_t sweep [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected line level for cycle k of a frame carrying d.
  function automatic logic exp_bit(input logic [D-1:0] d, input int k, input int bc);
    int b;
    b = k / bc;
    if (b == 0)      return 1'b0;
    else if (b <= D) return d[b-1];
    else if (b == D + 1) return ^d;
    else             return 1'b1;
  endfunction

  // Send one word and check every cycle of its frame; optionally pulse
  // in_valid with 4'h5 at frame cycle pulse_at (-1 for none).
  task automatic send_frame(input logic [D-1:0] d, input logic [D:0] exp_code,
                            input int bc, input int pulse_at);
    int total;
    logic [D:0] rx;
    total = (D + 3) * bc;
    rx = '0;
    @(negedge clk);
    check("ready_before_accept", 32'(rdy), 32'd1);
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("code_word", 32'(code), 32'(exp_code));
    check("code_word_even", 32'(^code), 32'd0);
    for (int k = 0; k < total; k++) begin
      if (k == pulse_at) begin
        in_valid = 1'b1;
        in_data  = 4'h5;
      end else if (k == pulse_at + 1) begin
        in_valid = 1'b0;
      end
      check("tx_bit", 32'(tx), 32'(exp_bit(d, k, bc)));
      check("busy_in_frame", 32'(bsy), 32'd1);
      check("ready_in_frame", 32'(rdy), 32'd0);
      check("frame_done", 32'(done), 32'(k == total - 1));
      if ((k % bc) == (bc / 2) && (k / bc) >= 1 && (k / bc) <= D + 1)
        rx[(k / bc) - 1] = tx;
      @(negedge clk);
    end
    check("tx_idle_after", 32'(tx), 32'd1);
    check("busy_after", 32'(bsy), 32'd0);
    check("ready_after", 32'(rdy), 32'd1);
    check("done_after", 32'(done), 32'd0);
    check("rx_data", 32'(rx[D-1:0]), 32'(d));
    check("checker_no_error", 32'(^rx), 32'd0);
    check("code_word_held", 32'(code), 32'(exp_code));
  endtask

  logic bb_tx [15];

  initial begin
    sweep[0]  = '{4'h0, 5'h00}; sweep[1]  = '{4'h1, 5'h03};
    sweep[2]  = '{4'h2, 5'h05}; sweep[3]  = '{4'h3, 5'h06};
    sweep[4]  = '{4'h4, 5'h09}; sweep[5]  = '{4'h5, 5'h0A};
    sweep[6]  = '{4'h6, 5'h0C}; sweep[7]  = '{4'h7, 5'h0F};
    sweep[8]  = '{4'h8, 5'h11}; sweep[9]  = '{4'h9, 5'h12};
    sweep[10] = '{4'hA, 5'h14}; sweep[11] = '{4'hB, 5'h17};
    sweep[12] = '{4'hC, 5'h18}; sweep[13] = '{4'hD, 5'h1B};
    sweep[14] = '{4'hE, 5'h1D}; sweep[15] = '{4'hF, 5'h1E};
    // Frame 4'h0, one idle cycle, frame 4'h7.
    bb_tx = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
              1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    // Reset with a valid word pending.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 4'hF;
    sel      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sel = 1'b0;
      #1;
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_ready", 32'(rdy), 32'd1);
      check("rst_busy", 32'(bsy), 32'd0);
      check("rst_code", 32'(code), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      sel = 1'b1;
      #1;
      check("rst_tx_bc3", 32'(tx), 32'd1);
      check("rst_code_bc3", 32'(code), 32'd0);
    end
    sel      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single frame 4'b1011 at one clock per bit.
    send_frame(4'b1011, 5'b10111, 1, -1);

    // Sweep of all words at three clocks per bit.
    sel = 1'b1;
    for (int i = 0; i < 16; i++) send_frame(sweep[i].data, sweep[i].code, 3, -1);
    sel = 1'b0;

    // Back-to-back with in_valid held high.
    @(negedge clk);
    in_data  = 4'h0;
    in_valid = 1'b1;
    @(negedge clk);
    in_data = 4'h7;
    for (int k = 0; k < 15; k++) begin
      if (k == 8) in_valid = 1'b0;
      check("b2b_tx", 32'(tx), 32'(bb_tx[k]));
      check("b2b_ready", 32'(rdy), 32'(k == 7));
      check("b2b_busy", 32'(bsy), 32'(k != 7));
      if (k == 0) check("b2b_code0", 32'(code), 32'h00);
      if (k == 8) check("b2b_code7", 32'(code), 32'h0F);
      @(negedge clk);
    end
    check("b2b_idle_tx", 32'(tx), 32'd1);
    check("b2b_idle_ready", 32'(rdy), 32'd1);

    // Reset during data bit 2 of a 4'hA frame.
    @(negedge clk);
    in_data  = 4'hA;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_tx_before_reset", 32'(tx), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_busy", 32'(bsy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_ready", 32'(rdy), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_rst_no_done", 32'(done), 32'd0);
      check("post_rst_tx", 32'(tx), 32'd1);
    end
    send_frame(4'hA, 5'b10100, 1, -1);

    // Word offered during PARITY of a 4'h3 frame must be ignored.
    send_frame(4'h3, 5'b00110, 1, 5);
    @(negedge clk);
    check("ignore_busy", 32'(bsy), 32'd0);
    check("ignore_code", 32'(code), 32'h06);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
